// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide memory port.
// Hits resolve in the same cycle; a miss stalls the pipeline while the FSM swaps lines.
module dcache_dm #(
   parameter int  LINE_ADDR_LEN = 2,
   parameter int  SET_ADDR_LEN  = 3,
   localparam int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [31:0]                      addr,
   input  logic                             rd_req,
   input  logic                             wr_req,
   input  logic [31:0]                      wr_data,
   output logic [31:0]                      rd_data,
   output logic                             miss,
   output logic [31:0]                      mem_addr,
   output logic                             mem_rd_req,
   output logic                             mem_wr_req,
   output logic [(32 << LINE_ADDR_LEN)-1:0] mem_wr_line,
   input  logic [(32 << LINE_ADDR_LEN)-1:0] mem_rd_line,
   input  logic                             mem_gnt
);

   localparam int SETS   = 1 << SET_ADDR_LEN;
   localparam int LINE_W = 32 << LINE_ADDR_LEN;
   localparam int OFS_W  = LINE_ADDR_LEN + 2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SWAP_OUT   = 2'd1,
      SWAP_IN    = 2'd2,
      SWAP_IN_OK = 2'd3
   } state_e;

   state_e                    state_q, state_d;
   logic [SETS-1:0]           valid_q, valid_d;
   logic [SETS-1:0]           dirty_q, dirty_d;
   logic [TAG_ADDR_LEN-1:0]   tag_q  [SETS];
   logic [LINE_W-1:0]         line_q [SETS];
   logic [LINE_W-1:0]         fill_q;

   logic [LINE_ADDR_LEN-1:0]  word_idx;
   logic [SET_ADDR_LEN-1:0]   set_idx;
   logic [TAG_ADDR_LEN-1:0]   addr_tag;
   logic                      req;
   logic                      hit;
   logic                      store_hit;
   logic [31:0]               cur_word;
   logic                      unused_addr_bits;

   // Address split: tag | set | word | byte (byte bits are ignored).
   assign word_idx         = addr[OFS_W-1:2];
   assign set_idx          = addr[OFS_W+SET_ADDR_LEN-1:OFS_W];
   assign addr_tag         = addr[31:32-TAG_ADDR_LEN];
   assign unused_addr_bits = ^addr[1:0];

   assign req       = rd_req | wr_req;
   assign hit       = req & valid_q[set_idx] & (tag_q[set_idx] == addr_tag);
   assign store_hit = (state_q == IDLE) & hit & wr_req;
   assign cur_word  = line_q[set_idx][{word_idx, 5'd0} +: 32];

   assign miss    = (state_q != IDLE) | (req & ~hit);
   assign rd_data = (rd_req & ~miss) ? cur_word : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req & ~hit) begin
               state_d = (valid_q[set_idx] & dirty_q[set_idx]) ? SWAP_OUT : SWAP_IN;
            end
         end
         SWAP_OUT: begin
            if (mem_gnt) state_d = SWAP_IN;
         end
         SWAP_IN: begin
            if (mem_gnt) state_d = SWAP_IN_OK;
         end
         SWAP_IN_OK: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory port is purely a function of state, so reset drops requests at once.
   always_comb begin
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = 32'd0;
      mem_wr_line = '0;
      case (state_q)
         SWAP_OUT: begin
            mem_wr_req  = 1'b1;
            mem_addr    = {tag_q[set_idx], set_idx, {OFS_W{1'b0}}};
            mem_wr_line = line_q[set_idx];
         end
         SWAP_IN: begin
            mem_rd_req = 1'b1;
            mem_addr   = {addr_tag, set_idx, {OFS_W{1'b0}}};
         end
         default: begin
            mem_rd_req = 1'b0;
         end
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      if (state_q == SWAP_IN_OK) begin
         valid_d[set_idx] = 1'b1;
         dirty_d[set_idx] = 1'b0;
      end else if (store_hit) begin
         dirty_d[set_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag/data storage and the fill buffer carry no reset; valid bits gate them.
   always_ff @(posedge clk) begin
      if ((state_q == SWAP_IN) && mem_gnt) begin
         fill_q <= mem_rd_line;
      end
      if (state_q == SWAP_IN_OK) begin
         line_q[set_idx] <= fill_q;
         tag_q[set_idx]  <= addr_tag;
      end else if (store_hit) begin
         line_q[set_idx][{word_idx, 5'd0} +: 32] <= wr_data;
      end
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed scenarios plus randomized accesses checked against an
// architectural memory model with a simple per-set residency model.
module tb_dcache_dm;

   logic         clk;
   logic         rst;
   logic [31:0]  addr;
   logic         rd_req;
   logic         wr_req;
   logic [31:0]  wr_data;
   logic [31:0]  rd_data;
   logic         miss;
   logic [31:0]  mem_addr;
   logic         mem_rd_req;
   logic         mem_wr_req;
   logic [127:0] mem_wr_line;
   logic [127:0] mem_rd_line;
   logic         mem_gnt;

   dcache_dm dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .rd_req     (rd_req),
      .wr_req     (wr_req),
      .wr_data    (wr_data),
      .rd_data    (rd_data),
      .miss       (miss),
      .mem_addr   (mem_addr),
      .mem_rd_req (mem_rd_req),
      .mem_wr_req (mem_wr_req),
      .mem_wr_line(mem_wr_line),
      .mem_rd_line(mem_rd_line),
      .mem_gnt    (mem_gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Reference model: architectural word values, backing memory, and which line each set holds.
   logic [31:0] arch    [logic [31:0]];
   logic [31:0] mainmem [logic [31:0]];
   logic        m_valid [8];
   logic        m_dirty [8];
   logic [24:0] m_tag   [8];

   int          e_miss;
   logic [31:0] e_rdata;
   logic        e_wb;
   logic [31:0] e_wb_addr;
   logic [127:0] e_wb_line;
   logic        e_fill;
   logic [31:0] e_fill_addr;

   int          a_miss_cnt;
   logic [31:0] a_rdata;
   logic        a_saw_wr;
   logic [31:0] a_wr_addr;
   logic [127:0] a_wr_line;
   logic        a_saw_rd;
   logic [31:0] a_rd_addr;
   logic        a_timeout;
   logic        a_proto_bad;

   function automatic logic [31:0] init_pat(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] main_rd(input logic [31:0] a);
      if (mainmem.exists(a)) return mainmem[a];
      return init_pat(a);
   endfunction

   function automatic logic [31:0] arch_rd(input logic [31:0] a);
      if (arch.exists(a)) return arch[a];
      return main_rd(a);
   endfunction

   function automatic logic [127:0] main_line(input logic [31:0] base);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = main_rd(base + 32'(4*i));
      return l;
   endfunction

   function automatic logic [127:0] arch_line(input logic [31:0] base);
      logic [127:0] l;
      for (int i = 0; i < 4; i++) l[i*32 +: 32] = arch_rd(base + 32'(4*i));
      return l;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 8; s++) begin
         if (m_valid[s] && m_dirty[s]) begin
            for (int i = 0; i < 4; i++) arch.delete({m_tag[s], 3'(s), 4'd0} + 32'(4*i));
         end
         m_valid[s] = 1'b0;
         m_dirty[s] = 1'b0;
         m_tag[s]   = '0;
      end
   endtask

   task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input int nw, input int nr);
      logic [2:0]  s;
      logic [24:0] t;
      logic [31:0] wa;
      s  = a[6:4];
      t  = a[31:7];
      wa = {a[31:2], 2'b00};
      e_miss = 0; e_wb = 1'b0; e_fill = 1'b0;
      e_wb_addr = '0; e_wb_line = '0; e_fill_addr = '0;
      if ((rd || wr) && !(m_valid[s] && m_tag[s] == t)) begin
         e_fill      = 1'b1;
         e_fill_addr = {a[31:4], 4'd0};
         e_miss      = nr + 2;
         if (m_valid[s] && m_dirty[s]) begin
            e_wb      = 1'b1;
            e_wb_addr = {m_tag[s], s, 4'd0};
            e_wb_line = arch_line(e_wb_addr);
            for (int i = 0; i < 4; i++) mainmem[e_wb_addr + 32'(4*i)] = arch_rd(e_wb_addr + 32'(4*i));
            e_miss    = e_miss + nw;
         end
         m_valid[s] = 1'b1;
         m_dirty[s] = 1'b0;
         m_tag[s]   = t;
      end
      e_rdata = rd ? arch_rd(wa) : 32'd0;
      if (wr) begin
         arch[wa]   = d;
         m_dirty[s] = 1'b1;
      end
   endtask

   // Drives one access and acts as the memory: grants a write-back after nw cycles, a fill after nr.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int nw, input int nr);
      int wcnt;
      int rcnt;
      wcnt = 0; rcnt = 0;
      a_miss_cnt = 0; a_rdata = '0; a_saw_wr = 1'b0; a_wr_addr = '0; a_wr_line = '0;
      a_saw_rd = 1'b0; a_rd_addr = '0; a_timeout = 1'b1; a_proto_bad = 1'b0;
      rd_req = rd; wr_req = wr; addr = a; wr_data = d;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (mem_rd_req && mem_wr_req) a_proto_bad = 1'b1;
         if (mem_addr[3:0] != 4'd0) a_proto_bad = 1'b1;
         if (!miss) begin
            a_rdata   = rd_data;
            a_timeout = 1'b0;
            break;
         end
         a_miss_cnt++;
         if (mem_wr_req) begin
            if (!a_saw_wr) begin
               a_wr_addr = mem_addr;
               a_wr_line = mem_wr_line;
            end
            a_saw_wr = 1'b1;
            wcnt++;
            if (wcnt == nw) mem_gnt = 1'b1;
         end else if (mem_rd_req) begin
            if (!a_saw_rd) a_rd_addr = mem_addr;
            a_saw_rd = 1'b1;
            rcnt++;
            if (rcnt == nr) begin
               mem_gnt     = 1'b1;
               mem_rd_line = main_line(mem_addr);
            end
         end
         @(posedge clk);
         #1;
         mem_gnt = 1'b0;
      end
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_cnt++;
      if (miss !== 1'b0) $display("FAIL reset_miss: got %b want 0", miss); else pass_cnt++;
      chk_cnt++;
      if ({mem_rd_req, mem_wr_req} !== 2'b00)
         $display("FAIL reset_mem_req: got %b want 00", {mem_rd_req, mem_wr_req});
      else pass_cnt++;
      chk_cnt++;
      if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
      chk_cnt++;
      if (mem_wr_line !== 128'd0) $display("FAIL reset_mem_wr_line: got %h want 0", mem_wr_line); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (miss !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 || rd_data !== 32'd0) bad++;
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL idle_no_request: got %0d bad cycles want 0", bad); else pass_cnt++;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_cold_read();
      mainmem[32'h10] = 32'hA; mainmem[32'h14] = 32'hB;
      mainmem[32'h18] = 32'hC; mainmem[32'h1C] = 32'hD;
      model_access(1'b1, 1'b0, 32'h14, 32'd0, 1, 3);
      access(1'b1, 1'b0, 32'h14, 32'd0, 1, 3);
      chk_cnt++;
      if (a_miss_cnt !== 5) $display("FAIL cold_miss_cycles: got %0d want 5", a_miss_cnt); else pass_cnt++;
      chk_cnt++;
      if (a_rd_addr !== 32'h10) $display("FAIL cold_fill_addr: got %h want 00000010", a_rd_addr); else pass_cnt++;
      chk_cnt++;
      if (a_rdata !== 32'hB) $display("FAIL cold_rd_data: got %h want 0000000b", a_rdata); else pass_cnt++;
      chk_cnt++;
      if (a_saw_wr !== 1'b0) $display("FAIL cold_no_writeback: got %b want 0", a_saw_wr); else pass_cnt++;
   endtask

   task automatic test_hit_after_fill();
      logic [31:0] addrs [3];
      logic [31:0] want  [3];
      addrs = '{32'h10, 32'h18, 32'h1C};
      want  = '{32'hA, 32'hC, 32'hD};
      for (int i = 0; i < 3; i++) begin
         model_access(1'b1, 1'b0, addrs[i], 32'd0, 1, 1);
         access(1'b1, 1'b0, addrs[i], 32'd0, 1, 1);
         chk_cnt++;
         if (a_miss_cnt !== 0 || a_rdata !== want[i])
            $display("FAIL hit_read_%0d: got miss=%0d data=%h want miss=0 data=%h", i, a_miss_cnt, a_rdata, want[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_store_evict();
      model_access(1'b0, 1'b1, 32'h14, 32'hCAFE_F00D, 1, 1);
      access(1'b0, 1'b1, 32'h14, 32'hCAFE_F00D, 1, 1);
      chk_cnt++;
      if (a_miss_cnt !== 0) $display("FAIL store_hit_miss: got %0d want 0", a_miss_cnt); else pass_cnt++;
      model_access(1'b1, 1'b0, 32'h94, 32'd0, 2, 1);
      access(1'b1, 1'b0, 32'h94, 32'd0, 2, 1);
      chk_cnt++;
      if (a_wr_addr !== 32'h10) $display("FAIL evict_wb_addr: got %h want 00000010", a_wr_addr); else pass_cnt++;
      chk_cnt++;
      if (a_wr_line[63:32] !== 32'hCAFE_F00D)
         $display("FAIL evict_wb_word1: got %h want cafef00d", a_wr_line[63:32]);
      else pass_cnt++;
      chk_cnt++;
      if (a_wr_line !== e_wb_line) $display("FAIL evict_wb_line: got %h want %h", a_wr_line, e_wb_line); else pass_cnt++;
      chk_cnt++;
      if (a_rd_addr !== 32'h90) $display("FAIL evict_fill_addr: got %h want 00000090", a_rd_addr); else pass_cnt++;
      chk_cnt++;
      if (a_miss_cnt !== 5) $display("FAIL evict_miss_cycles: got %0d want 5", a_miss_cnt); else pass_cnt++;
      chk_cnt++;
      if (a_rdata !== e_rdata) $display("FAIL evict_rd_data: got %h want %h", a_rdata, e_rdata); else pass_cnt++;
   endtask

   task automatic test_store_miss();
      model_access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 1, 2);
      access(1'b0, 1'b1, 32'h204, 32'h1234_5678, 1, 2);
      chk_cnt++;
      if (a_rd_addr !== 32'h200 || a_saw_wr !== 1'b0 || a_miss_cnt !== 4)
         $display("FAIL store_miss_fill: got addr=%h wb=%b miss=%0d want addr=00000200 wb=0 miss=4",
                  a_rd_addr, a_saw_wr, a_miss_cnt);
      else pass_cnt++;
      model_access(1'b1, 1'b0, 32'h204, 32'd0, 1, 1);
      access(1'b1, 1'b0, 32'h204, 32'd0, 1, 1);
      chk_cnt++;
      if (a_miss_cnt !== 0 || a_rdata !== 32'h1234_5678)
         $display("FAIL store_miss_readback: got miss=%0d data=%h want miss=0 data=12345678", a_miss_cnt, a_rdata);
      else pass_cnt++;
      // A conflicting read must write the line back, proving dirty was set.
      model_access(1'b1, 1'b0, 32'h004, 32'd0, 1, 1);
      access(1'b1, 1'b0, 32'h004, 32'd0, 1, 1);
      chk_cnt++;
      if (a_saw_wr !== 1'b1 || a_wr_addr !== 32'h200 || a_wr_line[63:32] !== 32'h1234_5678)
         $display("FAIL store_miss_dirty_wb: got wb=%b addr=%h word1=%h want wb=1 addr=00000200 word1=12345678",
                  a_saw_wr, a_wr_addr, a_wr_line[63:32]);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous();
      model_access(1'b1, 1'b0, 32'h18, 32'd0, 1, 1);
      access(1'b1, 1'b0, 32'h18, 32'd0, 1, 1);
      model_access(1'b1, 1'b1, 32'h18, 32'h55, 1, 1);
      access(1'b1, 1'b1, 32'h18, 32'h55, 1, 1);
      chk_cnt++;
      if (a_miss_cnt !== 0 || a_rdata !== 32'hC)
         $display("FAIL simul_old_word: got miss=%0d data=%h want miss=0 data=0000000c", a_miss_cnt, a_rdata);
      else pass_cnt++;
      model_access(1'b1, 1'b0, 32'h18, 32'd0, 1, 1);
      access(1'b1, 1'b0, 32'h18, 32'd0, 1, 1);
      chk_cnt++;
      if (a_miss_cnt !== 0 || a_rdata !== 32'h55)
         $display("FAIL simul_new_word: got miss=%0d data=%h want miss=0 data=00000055", a_miss_cnt, a_rdata);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      model_access(1'b1, 1'b0, 32'h94, 32'd0, 1, 2);
      access(1'b1, 1'b0, 32'h94, 32'd0, 1, 2);
      chk_cnt++;
      if (a_wr_line !== e_wb_line || a_wr_line[95:64] !== 32'h55)
         $display("FAIL resetmid_prep_wb: got %h want %h", a_wr_line, e_wb_line);
      else pass_cnt++;
      rd_req = 1'b1; wr_req = 1'b0; addr = 32'h14;
      @(negedge clk);
      chk_cnt++;
      if (miss !== 1'b1) $display("FAIL resetmid_miss: got %b want 1", miss); else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (mem_rd_req !== 1'b1 || mem_addr !== 32'h10)
         $display("FAIL resetmid_swap_in: got req=%b addr=%h want req=1 addr=00000010", mem_rd_req, mem_addr);
      else pass_cnt++;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_cnt++;
      if (mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 || mem_addr !== 32'd0)
         $display("FAIL resetmid_async_drop: got rd=%b wr=%b addr=%h want 0 0 00000000",
                  mem_rd_req, mem_wr_req, mem_addr);
      else pass_cnt++;
      rd_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      model_access(1'b1, 1'b0, 32'h14, 32'd0, 1, 1);
      access(1'b1, 1'b0, 32'h14, 32'd0, 1, 1);
      chk_cnt++;
      if (a_miss_cnt !== 3 || a_rd_addr !== 32'h10 || a_rdata !== 32'hCAFE_F00D)
         $display("FAIL resetmid_refill: got miss=%0d addr=%h data=%h want miss=3 addr=00000010 data=cafef00d",
                  a_miss_cnt, a_rd_addr, a_rdata);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic        rd;
      logic        wr;
      logic [24:0] t;
      logic [31:0] a;
      logic [31:0] d;
      int          nw;
      int          nr;
      int          sel;
      for (int n = 0; n < 200; n++) begin
         sel = int'($urandom_range(0, 9));
         rd  = (sel < 5) || (sel == 8);
         wr  = (sel >= 5 && sel <= 8);
         t   = ($urandom_range(0, 4) == 4) ? 25'h1ABCDE5 : 25'($urandom_range(0, 2));
         a   = {t, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         d   = $urandom;
         nw  = int'($urandom_range(1, 4));
         nr  = int'($urandom_range(1, 4));
         model_access(rd, wr, a, d, nw, nr);
         access(rd, wr, a, d, nw, nr);
         chk_cnt++;
         if (a_timeout || a_proto_bad)
            $display("FAIL rand_%0d_protocol: got timeout=%b proto_bad=%b want 0 0", n, a_timeout, a_proto_bad);
         else pass_cnt++;
         chk_cnt++;
         if (a_miss_cnt !== e_miss) $display("FAIL rand_%0d_miss_cycles: got %0d want %0d", n, a_miss_cnt, e_miss);
         else pass_cnt++;
         chk_cnt++;
         if (a_rdata !== e_rdata) $display("FAIL rand_%0d_rd_data: got %h want %h", n, a_rdata, e_rdata);
         else pass_cnt++;
         chk_cnt++;
         if (a_saw_wr !== e_wb || a_wr_addr !== e_wb_addr || a_wr_line !== e_wb_line)
            $display("FAIL rand_%0d_writeback: got %b %h %h want %b %h %h", n, a_saw_wr, a_wr_addr, a_wr_line,
                     e_wb, e_wb_addr, e_wb_line);
         else pass_cnt++;
         chk_cnt++;
         if (a_saw_rd !== e_fill || a_rd_addr !== e_fill_addr)
            $display("FAIL rand_%0d_fill: got %b %h want %b %h", n, a_saw_rd, a_rd_addr, e_fill, e_fill_addr);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
      mem_gnt = 1'b0; mem_rd_line = '0;
      #2;
      test_reset();
      test_cold_read();
      test_hit_after_fill();
      test_store_evict();
      test_store_miss();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
